// File: rtl/status_value_rle_pkg.sv
// ----------------------------------------------------------------------------
// status_value_rle_pkg
// Shared definitions for the status_value run-length drain stage:
//   - default parameter values (WIDTH must match the upstream vector)
//   - the two accumulator states (no run / run open)
//   - helper to size the idle counter so it can hold TIMEOUT
// ----------------------------------------------------------------------------
package status_value_rle_pkg;

   localparam int DEF_WIDTH     = 4;
   localparam int DEF_CNT_WIDTH = 4;
   localparam int DEF_TIMEOUT   = 16;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_OPEN  = 1'b1
   } rle_state_e;

   // Bits needed to count 0..timeout inclusive, never less than one.
   function automatic int idle_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/status_value_rle_tok_reg.sv
// ----------------------------------------------------------------------------
// status_value_rle_tok_reg
// One-deep valid/ready output register for run-length tokens.
// A load captures a new token (taking priority over a same-cycle accept);
// otherwise an accepted token clears valid, and a pending token holds its
// value and count stable until accepted.
// Ports:
//   clk, rsn            clock, synchronous active-low reset
//   load                capture load_value/load_count this edge
//   load_value/count    token to capture
//   ready               downstream accepts when valid & ready at the edge
//   valid/value/count   registered token outputs
// ----------------------------------------------------------------------------
module status_value_rle_tok_reg #(
   parameter int WIDTH     = 4,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rsn,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_value,
   input  logic [CNT_WIDTH-1:0] load_count,
   input  logic                 ready,
   output logic                 valid,
   output logic [WIDTH-1:0]     value,
   output logic [CNT_WIDTH-1:0] count
);

   // Token register: load, clear on accept, or hold.
   always_ff @(posedge clk) begin
      if (!rsn) begin
         valid <= 1'b0;
         value <= '0;
         count <= '0;
      end else if (load) begin
         valid <= 1'b1;
         value <= load_value;
         count <= load_count;
      end else if (ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

endmodule

// File: rtl/status_value_rle.sv
// ----------------------------------------------------------------------------
// status_value_rle
// Drain stage for status_value_vector: pulls head entries and merges runs of
// identical values into (value, count) tokens sent on a valid/ready port.
// A run closes on a differing value, on reaching MAX_RUN, after TIMEOUT idle
// cycles, or on flush; the token appears the cycle after the closing event.
// Ports:
//   clk_i, rsn_i            clock, synchronous active-low reset
//   sv_value_i, sv_valid_i  vector head (combinational)
//   sv_pull_o               consume head this edge (combinational)
//   flush_i                 level request to close the open run
//   tok_value_o/count_o     token payload (count is 1..MAX_RUN)
//   tok_valid_o, tok_ready_i token handshake
//   busy_o                  run open or token pending (registered)
// ----------------------------------------------------------------------------
module status_value_rle
   import status_value_rle_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic [WIDTH-1:0]     sv_value_i,
   input  logic                 sv_valid_i,
   output logic                 sv_pull_o,
   input  logic                 flush_i,
   output logic [WIDTH-1:0]     tok_value_o,
   output logic [CNT_WIDTH-1:0] tok_count_o,
   output logic                 tok_valid_o,
   input  logic                 tok_ready_i,
   output logic                 busy_o
);

   localparam int                   IDLE_W   = idle_width(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] MAX_RUN  = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
   localparam logic [IDLE_W-1:0]    IDLE_MAX = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0]    IDLE_ONE = IDLE_W'(1'b1);

   rle_state_e           state_r, state_s;
   logic [WIDTH-1:0]     acc_value_r, acc_value_s;
   logic [CNT_WIDTH-1:0] acc_count_r, acc_count_s;
   logic [IDLE_W-1:0]    idle_cnt_r, idle_cnt_s;
   logic                 busy_r, busy_s;
   logic                 match_s, room_s, out_free_s, pull_s, emit_s;

   assign match_s    = (sv_value_i == acc_value_r);
   assign room_s     = (acc_count_r != MAX_RUN);
   assign out_free_s = ~tok_valid_o | tok_ready_i;

   // A head is taken when it extends the run, starts one, or the closed run
   // can be handed to a free output slot. Never during flush or reset.
   assign pull_s = rsn_i & sv_valid_i & ~flush_i &
                   ((state_r == ST_EMPTY) | (match_s & room_s) | out_free_s);
   assign sv_pull_o = pull_s;
   assign busy_o    = busy_r;

   // Next-state logic for accumulator, idle counter and token emission.
   always_comb begin
      state_s     = state_r;
      acc_value_s = acc_value_r;
      acc_count_s = acc_count_r;
      idle_cnt_s  = idle_cnt_r;
      emit_s      = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            idle_cnt_s = '0;
            if (pull_s) begin
               state_s     = ST_OPEN;
               acc_value_s = sv_value_i;
               acc_count_s = CNT_ONE;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_OPEN: begin
            if (pull_s) begin
               idle_cnt_s = '0;
               if (match_s && room_s) begin
                  acc_count_s = acc_count_r + CNT_ONE;
               end else begin
                  // pull here implies out_free, so the slot can take the run
                  emit_s      = 1'b1;
                  acc_value_s = sv_value_i;
                  acc_count_s = CNT_ONE;
               end
            end else if (out_free_s && (flush_i || (idle_cnt_r == IDLE_MAX))) begin
               emit_s      = 1'b1;
               state_s     = ST_EMPTY;
               acc_count_s = '0;
               idle_cnt_s  = '0;
            end else if (idle_cnt_r != IDLE_MAX) begin
               idle_cnt_s = idle_cnt_r + IDLE_ONE;
            end else begin
               idle_cnt_s = idle_cnt_r;
            end
         end
         default: begin
            state_s     = ST_EMPTY;
            acc_count_s = '0;
            idle_cnt_s  = '0;
         end
      endcase
   end

   // Busy is the registered view of "run open or token pending" after this edge.
   always_comb begin
      busy_s = (state_s == ST_OPEN) | emit_s | (tok_valid_o & ~tok_ready_i);
   end

   // Accumulator, FSM and busy registers.
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_r     <= ST_EMPTY;
         acc_value_r <= '0;
         acc_count_r <= '0;
         idle_cnt_r  <= '0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         acc_value_r <= acc_value_s;
         acc_count_r <= acc_count_s;
         idle_cnt_r  <= idle_cnt_s;
         busy_r      <= busy_s;
      end
   end

   status_value_rle_tok_reg #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_tok_reg (
      .clk        (clk_i),
      .rsn        (rsn_i),
      .load       (emit_s),
      .load_value (acc_value_r),
      .load_count (acc_count_r),
      .ready      (tok_ready_i),
      .valid      (tok_valid_o),
      .value      (tok_value_o),
      .count      (tok_count_o)
   );

endmodule
